// File: rtl/sha256_pkg.sv
// Shared widths, FSM state type, sigma selector and rotation constants for the
// SHA-256 message schedule generator.
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int BLOCK_W   = 512;
    localparam int BUF_DEPTH = 16;

    localparam int S0_ROT_A = 7;
    localparam int S0_ROT_B = 18;
    localparam int S0_SHR   = 3;
    localparam int S1_ROT_A = 17;
    localparam int S1_ROT_B = 19;
    localparam int S1_SHR   = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        SIGMA0 = 1'b0,
        SIGMA1 = 1'b1
    } sigma_sel_e;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/sha256_sigma.sv
// Small-sigma function of the SHA-256 schedule; sel picks sigma0 (low) or
// sigma1 (high).
module sha256_sigma
    import sha256_pkg::*;
(
    input  logic              sel,
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    always_comb begin
        if (sel == SIGMA1) begin
            y = rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);
        end else begin
            y = rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
        end
    end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator: streams W[0..ROUNDS-1] over a valid/ready
// port. Optional stall counter enabled by SHA256_SCHED_STALL_CNT_EN.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [BLOCK_W-1:0] i_block,
    output logic               o_busy,
    output logic               o_w_valid,
    input  logic               i_w_ready,
    output logic [WORD_W-1:0]  o_w,
    output logic [5:0]         o_t,
    output logic               o_done
`ifdef SHA256_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]        o_stall_cnt
`endif
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_e            state_q;
    state_e            state_d;
    logic [5:0]        t_q;
    logic              done_q;
    logic [WORD_W-1:0] wbuf [BUF_DEPTH];

    logic              valid;
    logic              load;
    logic              hs;
    logic              last;
    logic              expand;
    logic [3:0]        idx_t;
    logic [3:0]        idx_m2;
    logic [3:0]        idx_m7;
    logic [3:0]        idx_m15;
    logic [WORD_W-1:0] s0;
    logic [WORD_W-1:0] s1;
    logic [WORD_W-1:0] w_new;
    logic [WORD_W-1:0] w_cur;

    assign valid  = (state_q == RUN);
    assign load   = (state_q == IDLE) && i_start;
    assign hs     = valid && i_w_ready;
    assign last   = (t_q == LAST_T);
    assign expand = (t_q[5:4] != 2'b00);

    // Circular-buffer taps: 4-bit subtraction wraps modulo the buffer depth.
    assign idx_t   = t_q[3:0];
    assign idx_m2  = idx_t - 4'd2;
    assign idx_m7  = idx_t - 4'd7;
    assign idx_m15 = idx_t - 4'd15;

    sha256_sigma u_sigma0 (
        .sel (SIGMA0),
        .x   (wbuf[idx_m15]),
        .y   (s0)
    );

    sha256_sigma u_sigma1 (
        .sel (SIGMA1),
        .x   (wbuf[idx_m2]),
        .y   (s1)
    );

    assign w_new = s1 + wbuf[idx_m7] + s0 + wbuf[idx_t];
    assign w_cur = expand ? w_new : wbuf[idx_t];

    assign o_busy    = valid;
    assign o_w_valid = valid;
    assign o_w       = valid ? w_cur : '0;
    assign o_t       = t_q;
    assign o_done    = done_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = RUN;
            RUN:     if (hs && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            t_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                t_q <= '0;
            end else if (hs) begin
                done_q <= last;
                t_q    <= last ? 6'd0 : t_q + 6'd1;
            end
        end
    end

    // NOTE: the word buffer has no reset; it is always fully reloaded before use.
    always_ff @(posedge i_clk) begin
        if (load) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                wbuf[i] <= i_block[BLOCK_W-1-i*WORD_W -: WORD_W];
            end
        end else if (hs && expand) begin
            wbuf[idx_t] <= w_new;
        end
    end

`ifdef SHA256_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset || load) begin
            stall_cnt_q <= '0;
        end else if (valid && !i_w_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
